// File: rtl/memory_bus_controller_pkg.sv
// Shared types and default sizing for the memory bus controller and its wait-cycle counter.
package memory_bus_controller_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_TIMEOUT = 15;
    localparam int CNT_W       = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

endpackage

// File: rtl/access_timeout_counter.sv
// Counts wait cycles of an outstanding memory access; hit flags the last cycle allowed without ack.
module access_timeout_counter
    import memory_bus_controller_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam logic [CNT_W-1:0] HIT_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Asserted during the cycle whose missing ack would make the count reach TIMEOUT.
    assign hit = enable && (cnt_q == HIT_VAL);

endmodule

// File: rtl/memory_bus_controller.sv
// Memory bus controller: turns single-cycle read/write requests into held memory strobes with ack/timeout.
//
// state  | meaning
// IDLE   | waiting for rd_req / wr_req
// READ   | mem_re held, waiting for mem_ack
// WRITE  | mem_we held, waiting for mem_ack
// FINISH | done pulse (plus MMD after a read)
// FAULT  | err pulse after conflict or timeout
module memory_bus_controller
    import memory_bus_controller_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic [DATA_W-1:0] mdr_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] M_bus,
    output logic              MMD,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   mbus_q;
    logic                re_q, we_q, mmd_q, busy_q, done_q, err_q;
    logic                cnt_clear, cnt_en, cnt_hit;

    assign cnt_clear = (state_q == ST_IDLE);
    assign cnt_en    = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !mem_ack;

    access_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .hit    (cnt_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mbus_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            mmd_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            mmd_q  <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rd_req && wr_req) begin
                        state_q <= ST_FAULT;
                        err_q   <= 1'b1;
                    end else if (rd_req) begin
                        addr_q  <= mar_in;
                        re_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_READ;
                    end else if (wr_req) begin
                        addr_q  <= mar_in;
                        wdata_q <= mdr_in;
                        we_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end
                end
                ST_READ, ST_WRITE: begin
                    // An ack in the timeout cycle still completes normally.
                    if (mem_ack) begin
                        if (state_q == ST_READ) begin
                            mbus_q <= mem_rdata;
                            mmd_q  <= 1'b1;
                        end
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_FINISH;
                    end else if (cnt_hit) begin
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= ST_FAULT;
                    end
                end
                ST_FINISH, ST_FAULT: state_q <= ST_IDLE;
                default:             state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_re    = re_q;
    assign mem_we    = we_q;
    assign M_bus     = mbus_q;
    assign MMD       = mmd_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_memory_bus_controller.sv
// Bench for memory_bus_controller: directed scenarios plus random traffic against a transaction-level model.
module tb_memory_bus_controller;

    localparam int TO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [15:0] mar_in = '0, mdr_in = '0;
    logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, M_bus;
    logic        mem_re, mem_we, mem_ack = 1'b0;
    logic        MMD, busy, done, err;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    int n_re, n_we, n_done, n_mmd, n_err;

    memory_bus_controller #(.DATA_W(16), .ADDR_W(16), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .wr_req    (wr_req),
        .mar_in    (mar_in),
        .mdr_in    (mdr_in),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .M_bus     (M_bus),
        .MMD       (MMD),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: an access is outstanding until ack or TO silent cycles.
    logic [15:0] e_addr = '0, e_wdata = '0, e_mbus = '0;
    logic        e_re = 0, e_we = 0, e_mmd = 0, e_busy = 0, e_done = 0, e_err = 0;
    bit          act = 0, m_read = 0;
    int          waited = 0;

    always @(posedge clk) begin
        if (rst) begin
            e_addr = '0; e_wdata = '0; e_mbus = '0;
            e_re = 0; e_we = 0; e_mmd = 0; e_done = 0; e_err = 0;
            act = 0; waited = 0;
        end else if (e_done || e_err) begin
            e_done = 0; e_err = 0; e_mmd = 0;
        end else if (act) begin
            if (mem_ack) begin
                e_done = 1;
                if (m_read) begin
                    e_mbus = mem_rdata;
                    e_mmd  = 1;
                end
                e_re = 0; e_we = 0; act = 0;
            end else begin
                waited++;
                if (waited == TO) begin
                    e_err = 1; e_re = 0; e_we = 0; act = 0;
                end
            end
        end else if (rd_req && wr_req) begin
            e_err = 1;
        end else if (rd_req) begin
            e_addr = mar_in; e_re = 1; act = 1; m_read = 1; waited = 0;
        end else if (wr_req) begin
            e_addr = mar_in; e_wdata = mdr_in; e_we = 1; act = 1; m_read = 0; waited = 0;
        end
        e_busy = act;
    end

    always @(negedge clk) begin
        if (chk_en)
            check("cycle_outputs",
                  {mem_addr, mem_wdata, M_bus, mem_re, mem_we, MMD, busy, done, err},
                  {e_addr, e_wdata, e_mbus, e_re, e_we, e_mmd, e_busy, e_done, e_err});
    end

    task automatic clr();
        n_re = 0; n_we = 0; n_done = 0; n_mmd = 0; n_err = 0;
    endtask

    task automatic cyc();
        @(negedge clk);
        n_re   += int'(mem_re);
        n_we   += int'(mem_we);
        n_done += int'(done);
        n_mmd  += int'(MMD);
        n_err  += int'(err);
    endtask

    initial begin
        int mode;
        clr();
        repeat (2) cyc();
        check("reset_state", {mem_addr, mem_wdata, M_bus, mem_re, mem_we, MMD, busy, done, err}, 64'h0);
        chk_en = 1'b1;
        rst = 1'b0;
        cyc();

        // Read, ack in fourth wait cycle
        clr(); mar_in = 16'h0040; rd_req = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 1) check("rd_addr", mem_addr, 16'h0040);
            if (i == 5) check("rd_done_mmd", {done, MMD}, 2'b11);
            rd_req = 1'b0;
            mem_ack = (i == 4);
            mem_rdata = (i == 4) ? 16'hBEEF : 16'($urandom);
        end
        mem_ack = 1'b0;
        check("rd_re_cycles", n_re, 4);
        check("rd_done_cnt", n_done, 1);
        check("rd_mmd_cnt", n_mmd, 1);
        check("rd_mbus", M_bus, 16'hBEEF);

        // Write, ack on first cycle
        clr(); mar_in = 16'h0100; mdr_in = 16'h1234; wr_req = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 1) check("wr_strobe_data", {mem_we, mem_wdata, mem_addr}, {1'b1, 16'h1234, 16'h0100});
            if (i == 2) check("wr_done_at_n2", {done, MMD}, 2'b10);
            wr_req = 1'b0;
            mdr_in = 16'($urandom);
            mem_ack = (i == 1);
        end
        mem_ack = 1'b0;
        check("wr_we_cycles", n_we, 1);
        check("wr_mmd_cnt", n_mmd, 0);

        // Timeout on read
        clr(); rd_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 16) check("to_err_pulse", {err, mem_re, done}, 3'b100);
            rd_req = 1'b0;
        end
        check("to_re_cycles", n_re, TO);
        check("to_err_cnt", n_err, 1);
        check("to_mbus_kept", M_bus, 16'hBEEF);

        // Conflicting requests
        clr(); rd_req = 1'b1; wr_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 1) check("conf_err_next", err, 1'b1);
            rd_req = 1'b0; wr_req = 1'b0;
        end
        check("conf_no_strobe", n_re + n_we, 0);
        check("conf_err_cnt", n_err, 1);

        // Reset during second wait cycle of a read
        clr(); rd_req = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            rd_req = 1'b0;
            if (i == 2) rst = 1'b1;
            if (i == 3) begin
                check("rst_mid_zero", {mem_addr, mem_wdata, M_bus, mem_re, mem_we, MMD, busy, done, err}, 64'h0);
                rst = 1'b0;
                clr();
            end
        end
        for (int i = 1; i <= 5; i++) begin
            cyc();
            mem_ack = 1'($urandom);
        end
        mem_ack = 1'b0;
        check("rst_no_pulses", n_done + n_mmd + n_err, 0);
        clr(); mar_in = 16'h0200; rd_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            rd_req = 1'b0;
            mem_ack = (i == 1);
            mem_rdata = (i == 1) ? 16'h5A5A : 16'h0000;
        end
        mem_ack = 1'b0;
        check("rst_then_read", {M_bus, 8'(n_done)}, {16'h5A5A, 8'd1});

        // Ack in the timeout cycle itself
        clr(); rd_req = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            rd_req = 1'b0;
            mem_ack = (i == TO);
            mem_rdata = (i == TO) ? 16'hC3C3 : 16'($urandom);
        end
        mem_ack = 1'b0;
        check("coinc_done_no_err", {8'(n_done), 8'(n_err), 8'(n_re)}, {8'd1, 8'd0, 8'(TO)});
        check("coinc_mbus", M_bus, 16'hC3C3);

        // Stray ack while idle
        clr();
        for (int i = 1; i <= 4; i++) begin
            cyc();
            mem_ack = 1'b1;
            mem_rdata = 16'($urandom);
        end
        mem_ack = 1'b0;
        cyc();
        check("stray_ack", {M_bus, 8'(n_done + n_mmd + n_err + n_re)}, {16'hC3C3, 8'd0});

        // Random traffic checked cycle by cycle against the model
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            if (i % 200 == 0) mode = $urandom_range(0, 3);
            rd_req = ($urandom_range(0, 3) == 0);
            wr_req = ($urandom_range(0, 3) == 0);
            mar_in = 16'($urandom);
            mdr_in = 16'($urandom);
            mem_rdata = 16'($urandom);
            case (mode)
                0: mem_ack = ($urandom_range(0, 1) == 0);
                1: mem_ack = ($urandom_range(0, 7) == 0);
                2: mem_ack = 1'b0;
                default: mem_ack = ($urandom_range(0, 15) == 0);
            endcase
            rst = ($urandom_range(0, 499) == 0);
        end
        rd_req = 1'b0; wr_req = 1'b0; mem_ack = 1'b0; rst = 1'b0;
        repeat (20) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/memory_bus_controller.md
MEMORY_BUS_CONTROLLER -- requirements
Module: memory_bus_controller

Interface
REQ-001 Parameter DATA_W, default 16, width of data path, MDR and M bus.
REQ-002 Parameter ADDR_W, default 16, memory address width.
REQ-003 Parameter TIMEOUT, default 15, maximum wait cycles for mem_ack before abort; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; synchronous and active-high.
REQ-006 rd_req  input  1  control-unit request: memory read into MDR.
REQ-007 wr_req  input  1  control-unit request: write MDR contents to memory.
REQ-008 mar_in  input  ADDR_W  address from MAR.
REQ-009 mdr_in  input  DATA_W  current MDR output (write data source).
REQ-010 mem_addr  output  ADDR_W  registered address to memory.
REQ-011 mem_wdata  output  DATA_W  registered write data.
REQ-012 mem_re / mem_we  output  1 each  read / write strobes, held for the whole access.
REQ-013 mem_rdata  input  DATA_W  read data, valid when mem_ack=1.
REQ-014 mem_ack  input  1  memory completion handshake.
REQ-015 M_bus  output  DATA_W  captured read data driven to MDR input mux.
REQ-016 MMD  output  1  one-cycle strobe loading M_bus into MDR.
REQ-017 busy / done / err  output  1 each  access in progress / one-cycle completion / one-cycle abort.

Function
REQ-018 FSM states IDLE, READ, WRITE, FINISH, FAULT; encodings in shared package.
REQ-019 IDLE, rd_req=1, wr_req=0: latch mar_in into mem_addr, assert mem_re, clear wait counter, go READ next cycle.
REQ-020 IDLE, wr_req=1, rd_req=0: latch mar_in and mdr_in, assert mem_we, go WRITE.
REQ-021 IDLE, rd_req=1 and wr_req=1 simultaneously: no memory strobe; go FAULT (err pulse one cycle later).
REQ-022 READ/WRITE: mem_addr, mem_wdata and strobe stable; requests ignored; busy=1.
REQ-023 READ with mem_ack=1: capture mem_rdata into M_bus register, drop mem_re, go FINISH.
REQ-024 WRITE with mem_ack=1: drop mem_we, go FINISH.
REQ-025 FINISH: done=1 for exactly one cycle; MMD=1 for that same cycle only after a read; return IDLE.
REQ-026 Wait counter 8-bit, increments each READ/WRITE cycle without mem_ack; reaching TIMEOUT with no ack: drop strobe, go FAULT; M_bus unchanged.
REQ-027 mem_ack on the same cycle the counter reaches TIMEOUT: ack wins, normal completion.
REQ-028 FAULT: err=1 one cycle, done=0, MMD=0; return IDLE.
REQ-029 mem_ack in IDLE/FINISH/FAULT ignored.
REQ-030 Minimum latency: request cycle N, ack at N+1 -> done/MMD at N+2; new request accepted in IDLE at N+3.
REQ-031 M_bus holds last captured read data until next successful read.

Reset
REQ-032 rst=1 at rising edge: state IDLE, counter 0, mem_re=mem_we=0, MMD=done=err=busy=0, mem_addr=0, mem_wdata=0, M_bus=0.
REQ-033 Reset mid-access aborts immediately; no done, err or MMD generated for aborted access.

Structure
REQ-034 Shared package holds state enum, default DATA_W/ADDR_W/TIMEOUT constants.
REQ-035 One sub-module: access_timeout_counter (clear, enable, hit output); FSM and registers in top.

Verification
REQ-036 Read: mar_in=0x0040, rd_req 1 cycle, ack after 3 cycles with rdata=0xBEEF -> M_bus=0xBEEF, MMD and done one cycle, mem_re high exactly 4 cycles.
REQ-037 Write: mar_in=0x0100, mdr_in=0x1234, ack next cycle -> mem_we/mem_wdata=0x1234 stable until ack, done at N+2, MMD=0.
REQ-038 Timeout: rd_req, no ack for TIMEOUT=15 cycles -> strobe drops, err one cycle, M_bus keeps prior 0xBEEF.
REQ-039 Conflict: rd_req=wr_req=1 -> no mem_re/mem_we ever, err one cycle later.
REQ-040 Reset mid-read at wait cycle 2 -> all outputs 0 next cycle, no done/MMD; later read completes normally.
REQ-041 Ack coincident with timeout cycle -> done, no err; stray ack in IDLE -> no output change.
